smu_dribble_ctl: RTL

Stack-cache dribbler controller for the stack manager unit. It watches the distance between `iu_optop` and its own `sc_bottom` register, and keeps the 64-entry stack cache between two watermarks. When the cache is too full it spills the oldest entry to memory. When it is too empty it fills one entry back from memory. It drives the stack cache's dribbler port (`smu_rf_addr`, `smu_we`, `smu_data`, with `iu_smu_data` returned) and a simple request/acknowledge memory port, and it honours `iu_smu_flush`.

---
 rtl/smu_dribble_ctl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/smu_dribble_ctl.sv
// Stack-cache dribbler: spills the oldest entry when the cache is above HI_WM
// and refills one entry from memory when it drops below LO_WM.
module smu_dribble_ctl #(
    parameter int HI_WM = 48,
    parameter int LO_WM = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dribble_en,
    input  logic [31:0] iu_optop,
    input  logic [31:0] fill_limit,
    input  logic        sc_bottom_wr_en,
    input  logic [31:0] sc_bottom_wr_data,
    input  logic        iu_smu_flush,
    input  logic [31:0] iu_smu_data,
    output logic [5:0]  smu_rf_addr,
    output logic        smu_we,
    output logic [31:0] smu_data,
    output logic        smu_mem_req,
    output logic        smu_mem_wr,
    output logic [31:0] smu_mem_addr,
    output logic [31:0] smu_mem_wdata,
    input  logic        mem_smu_ack,
    input  logic [31:0] mem_smu_rdata,
    output logic [31:0] smu_sc_bottom,
    output logic        smu_busy
);

    typedef enum logic [2:0] {IDLE, SP_RD, SP_REQ, FL_REQ, FL_WR} state_t;

    state_t      r_state;
    logic [31:0] r_sc_bottom;
    logic [31:0] r_spill;
    logic [31:0] r_fill;
    logic        r_cancel;
    logic        r_sp_first;

    logic [31:0] w_entries;
    logic [31:0] w_bot_up;
    logic        w_abort;
    logic        w_do_spill;
    logic        w_do_fill;
    logic        w_drop;

    assign w_entries  = (r_sc_bottom - iu_optop) >> 2;
    assign w_bot_up   = r_sc_bottom + 32'd4;
    assign w_abort    = iu_smu_flush | sc_bottom_wr_en;
    assign w_do_spill = dribble_en && (w_entries > 32'(HI_WM));
    assign w_do_fill  = dribble_en && (w_entries < 32'(LO_WM)) && (w_bot_up <= fill_limit);
    // A cancel raised in the ack cycle itself must drop the result too.
    assign w_drop     = r_cancel | w_abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sc_bottom <= '0;
            r_spill     <= '0;
            r_fill      <= '0;
            r_cancel    <= 1'b0;
            r_sp_first  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cancel <= 1'b0;
                    if (!w_abort) begin
                        if (w_do_spill)
                            r_state <= SP_RD;
                        else if (w_do_fill)
                            r_state <= FL_REQ;
                    end
                end
                SP_RD: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                    end else begin
                        r_state    <= SP_REQ;
                        r_sp_first <= 1'b1;
                    end
                end
                SP_REQ: begin
                    if (r_sp_first) begin
                        r_spill    <= iu_smu_data;
                        r_sp_first <= 1'b0;
                    end
                    if (w_abort)
                        r_cancel <= 1'b1;
                    if (mem_smu_ack) begin
                        r_state  <= IDLE;
                        r_cancel <= 1'b0;
                        if (!w_drop)
                            r_sc_bottom <= r_sc_bottom - 32'd4;
                    end
                end
                FL_REQ: begin
                    if (w_abort)
                        r_cancel <= 1'b1;
                    if (mem_smu_ack) begin
                        r_fill   <= mem_smu_rdata;
                        r_cancel <= 1'b0;
                        r_state  <= w_drop ? IDLE : FL_WR;
                    end
                end
                FL_WR: begin
                    r_state <= IDLE;
                    if (!w_abort)
                        r_sc_bottom <= w_bot_up;
                end
                default: r_state <= IDLE;
            endcase
            // Privileged write overrides any operation update in the same cycle.
            if (sc_bottom_wr_en)
                r_sc_bottom <= sc_bottom_wr_data;
        end
    end

    assign smu_busy      = (r_state != IDLE);
    assign smu_sc_bottom = r_sc_bottom;
    assign smu_rf_addr   = (r_state == SP_RD) ? r_sc_bottom[7:2] :
                           (r_state == FL_WR) ? w_bot_up[7:2] : 6'd0;
    // Write enable is the one output gated by a same-cycle flush or sc_bottom write.
    assign smu_we        = (r_state == FL_WR) && !w_abort;
    assign smu_data      = (r_state == FL_WR) ? r_fill : 32'd0;
    assign smu_mem_req   = (r_state == SP_REQ) || (r_state == FL_REQ);
    assign smu_mem_wr    = (r_state == SP_REQ);
    assign smu_mem_addr  = (r_state == SP_REQ) ? r_sc_bottom :
                           (r_state == FL_REQ) ? w_bot_up : 32'd0;
    // Cache read data arrives in the first request cycle, so it is forwarded
    // until the spill register holds it.
    assign smu_mem_wdata = (r_state != SP_REQ) ? 32'd0 :
                           r_sp_first ? iu_smu_data : r_spill;

endmodule
